// File: rtl/csi_raw_unpack_if.sv
// csi_raw_unpack_if
// Groups the byte-stream input and the href/vsync/raw pixel output of the
// CSI-2 RAW unpacker.
//   in_valid  - in_data carries a byte this cycle
//   in_sot    - with in_valid: in_data is byte 0 (DI) of a new packet
//   in_data   - packet byte stream
//   out_href  - out_raw carries a RAW8 payload pixel this cycle
//   out_vsync - high between Frame Start and Frame End
//   out_raw   - pixel value, RAW8 byte in the MSBs
// modport master: stream source / pixel sink (testbench, upstream lane merger)
// modport slave : the unpacker itself
interface csi_raw_unpack_if #(
  parameter int BITS = 8
);
  logic            in_valid;
  logic            in_sot;
  logic [7:0]      in_data;
  logic            out_href;
  logic            out_vsync;
  logic [BITS-1:0] out_raw;

  modport master (
    output in_valid, in_sot, in_data,
    input  out_href, out_vsync, out_raw
  );

  modport slave (
    input  in_valid, in_sot, in_data,
    output out_href, out_vsync, out_raw
  );
endinterface

// File: rtl/csi_raw_unpack.sv
// csi_raw_unpack
// Parses a merged, SoT-marked CSI-2 byte stream. FS/FE short packets on the
// selected virtual channel drive vsync; RAW8 long-packet payload bytes are
// emitted one per cycle as href-qualified pixels. All other packets are
// skipped. Frame/line counters and sticky format errors are reported.
// Ports:
//   pclk, rst_n - byte clock, asynchronous active-low reset
//   bus         - stream in / pixels out (csi_raw_unpack_if.slave)
//   frame_cnt   - completed frames (wrapping)
//   line_cnt    - RAW8 lines completed in the current frame (saturating)
//   err_wc      - sticky: RAW8 word count differed from WIDTH
//   err_lines   - sticky: line count differed from HEIGHT at FE
//   err_trunc   - sticky: new SoT arrived before the previous packet ended
module csi_raw_unpack #(
  parameter int         BITS   = 8,
  parameter int         WIDTH  = 1280,
  parameter int         HEIGHT = 960,
  parameter int         VC     = 0,
  parameter logic [7:0] DT_RAW = 8'h2A
) (
  input  logic                pclk,
  input  logic                rst_n,
  csi_raw_unpack_if.slave     bus,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         line_cnt,
  output logic                err_wc,
  output logic                err_lines,
  output logic                err_trunc
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    CRC     = 3'd3,
    SKIP    = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      hdr_idx_r, hdr_idx_s;
  logic [7:0]      di_r, di_s;
  logic [15:0]     wc_r, wc_s;
  // Wide enough for WC + 2 (payload plus CRC of a skipped packet).
  logic [16:0]     cnt_r, cnt_s;
  logic            href_r, href_s;
  logic            vsync_r, vsync_s;
  logic [BITS-1:0] raw_r, raw_s;
  logic [15:0]     frame_r, frame_s;
  logic [15:0]     line_r, line_s;
  logic            err_wc_r, err_wc_s;
  logic            err_lines_r, err_lines_s;
  logic            err_trunc_r, err_trunc_s;

  logic [5:0]      dt_s;
  logic            vc_ok_s;

  assign dt_s    = di_r[5:0];
  assign vc_ok_s = (di_r[7:6] == VC[1:0]);

  // Next-state and next-output computation for the packet parser.
  always_comb begin
    state_s     = state_r;
    hdr_idx_s   = hdr_idx_r;
    di_s        = di_r;
    wc_s        = wc_r;
    cnt_s       = cnt_r;
    href_s      = 1'b0;
    raw_s       = raw_r;
    vsync_s     = vsync_r;
    frame_s     = frame_r;
    line_s      = line_r;
    err_wc_s    = err_wc_r;
    err_lines_s = err_lines_r;
    err_trunc_s = err_trunc_r;

    if (bus.in_valid) begin
      if (bus.in_sot) begin
        // A SoT always restarts header parsing, abandoning any open packet.
        state_s   = HDR;
        hdr_idx_s = 2'd1;
        di_s      = bus.in_data;
        if (state_r != IDLE) begin
          err_trunc_s = 1'b1;
        end else begin
          err_trunc_s = err_trunc_r;
        end
      end else begin
        case (state_r)
          IDLE: begin
            state_s = IDLE;
          end
          HDR: begin
            case (hdr_idx_r)
              2'd1: begin
                wc_s[7:0] = bus.in_data;
                hdr_idx_s = 2'd2;
              end
              2'd2: begin
                wc_s[15:8] = bus.in_data;
                hdr_idx_s  = 2'd3;
              end
              default: begin
                // ECC byte: the header is complete, decode it.
                state_s = IDLE;
                if (dt_s == 6'h00 && vc_ok_s) begin
                  vsync_s     = 1'b1;
                  line_s      = 16'd0;
                  err_wc_s    = 1'b0;
                  err_lines_s = 1'b0;
                  err_trunc_s = 1'b0;
                end else if (dt_s == 6'h01 && vc_ok_s) begin
                  if (vsync_r) begin
                    vsync_s     = 1'b0;
                    frame_s     = frame_r + 16'd1;
                    err_lines_s = (line_r != 16'(HEIGHT));
                  end else begin
                    vsync_s = vsync_r;
                  end
                end else if (dt_s < 6'h10) begin
                  state_s = IDLE;
                end else if (dt_s == DT_RAW[5:0] && vc_ok_s && vsync_r) begin
                  err_wc_s = err_wc_r | (wc_r != 16'(WIDTH));
                  if (wc_r == 16'd0) begin
                    state_s = CRC;
                    cnt_s   = 17'd2;
                  end else begin
                    state_s = PAYLOAD;
                    cnt_s   = {1'b0, wc_r};
                  end
                end else begin
                  state_s = SKIP;
                  cnt_s   = {1'b0, wc_r} + 17'd2;
                end
              end
            endcase
          end
          PAYLOAD: begin
            href_s = 1'b1;
            raw_s  = BITS'(bus.in_data) << (BITS - 8);
            cnt_s  = cnt_r - 17'd1;
            if (cnt_r == 17'd1) begin
              state_s = CRC;
              cnt_s   = 17'd2;
              if (line_r != 16'hFFFF) begin
                line_s = line_r + 16'd1;
              end else begin
                line_s = line_r;
              end
            end else begin
              state_s = PAYLOAD;
            end
          end
          CRC, SKIP: begin
            cnt_s = cnt_r - 17'd1;
            if (cnt_r == 17'd1) begin
              state_s = IDLE;
            end else begin
              state_s = state_r;
            end
          end
          default: begin
            state_s = IDLE;
          end
        endcase
      end
    end else begin
      // Gap: everything holds, href drops.
      state_s = state_r;
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      hdr_idx_r   <= 2'd0;
      di_r        <= 8'd0;
      wc_r        <= 16'd0;
      cnt_r       <= 17'd0;
      href_r      <= 1'b0;
      vsync_r     <= 1'b0;
      raw_r       <= '0;
      frame_r     <= 16'd0;
      line_r      <= 16'd0;
      err_wc_r    <= 1'b0;
      err_lines_r <= 1'b0;
      err_trunc_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      hdr_idx_r   <= hdr_idx_s;
      di_r        <= di_s;
      wc_r        <= wc_s;
      cnt_r       <= cnt_s;
      href_r      <= href_s;
      vsync_r     <= vsync_s;
      raw_r       <= raw_s;
      frame_r     <= frame_s;
      line_r      <= line_s;
      err_wc_r    <= err_wc_s;
      err_lines_r <= err_lines_s;
      err_trunc_r <= err_trunc_s;
    end
  end

  assign bus.out_href  = href_r;
  assign bus.out_vsync = vsync_r;
  assign bus.out_raw   = raw_r;
  assign frame_cnt     = frame_r;
  assign line_cnt      = line_r;
  assign err_wc        = err_wc_r;
  assign err_lines     = err_lines_r;
  assign err_trunc     = err_trunc_r;

endmodule
